core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core: fetches each instruction over a ready-handshake instruction port, presents it to the instruction decoder, steps the ALU/memory/write-back phases, and updates the PC. It consumes the decoder's enables (`rd_e`, `jump_e`, `full_inst`) plus ALU and branch results, and drives instruction-memory, data-memory and register-file write control. It halts the core on `ecall`/`ebreak`, on an undecodable instruction, or on a misaligned control-flow target.

---
 rtl/core_sequencer_if.sv | 27 ++
 rtl/core_sequencer.sv | 171 +++++++++++++++++
 tb/tb_core_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle for core_sequencer.
// master: the sequencer side (drives requests/addresses).
// slave:  the memory side (drives ready and read data).
interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic        dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_addr,
    input  dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr,
    output dmem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM (fetch, decode, exec, mem, write-back).
// Optional feature macro: SEQ_PERF_CNT_EN enables the cycle and retired-instruction
// counters; when undefined both counter ports read as zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | request instruction at pc, latch it when imem_ready
// S_DECODE | decoder / register-file read settle; system or invalid -> halt
// S_EXEC   | ALU settle; loads and stores go to S_MEM
// S_MEM    | data access; stores retire here, loads continue to S_WB
// S_WB     | register write-back, retire, pc update
// S_HALT   | absorbing stop state, left only through rst
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  core_sequencer_if.master   bus,
  output logic [31:0]        inst,
  input  logic [16:0]        full_inst,
  input  logic               rd_e,
  input  logic               jump_e,
  input  logic [31:0]        alu_result,
  input  logic               branch_taken,
  output logic               rf_we,
  output logic [1:0]         wb_sel,
  output logic [31:0]        pc,
  output logic               retire,
  output logic               halt,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, inst_q, pc_next;
  logic        inst_load, pc_load, done, misaligned;
  logic        is_load, is_store, is_branch;

  // func7/func3 are decoded downstream; only the opcode field matters here.
  logic unused_full_inst;
  assign unused_full_inst = ^full_inst[16:7];

  assign is_load   = (inst_q[6:0] == OP_LOAD);
  assign is_store  = (inst_q[6:0] == OP_STORE);
  assign is_branch = (inst_q[6:0] == OP_BRANCH);

  assign bus.imem_addr = pc_q;
  assign bus.dmem_addr = alu_result;
  assign pc            = pc_q;
  assign inst          = inst_q;

  // Next PC by priority: jump (LSB cleared), taken branch, sequential.
  always_comb begin
    if (jump_e)
      pc_next = {alu_result[31:1], 1'b0};
    else if (is_branch && branch_taken)
      pc_next = alu_result;
    else
      pc_next = pc_q + 32'd4;
  end

  assign misaligned = (pc_next[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and control-output decode.
  always_comb begin
    state_d      = state_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    halt         = 1'b0;
    inst_load    = 1'b0;
    pc_load      = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = ~rst;
        if (bus.imem_ready) begin
          inst_load = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (full_inst[6:0] == OP_SYSTEM || full_inst[6:0] == 7'd0)
          state_d = S_HALT;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_store;
        if (bus.dmem_ready) begin
          if (is_store) done = 1'b1;
          else          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we  = rd_e;
        wb_sel = is_load ? 2'd1 : (jump_e ? 2'd2 : 2'd0);
        done   = 1'b1;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // A misaligned target stops the core without retiring or moving pc.
    if (done) begin
      if (misaligned) begin
        state_d = S_HALT;
      end else begin
        retire  = 1'b1;
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  // PC and instruction latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'h0000_0013;
    end else begin
      if (pc_load)   pc_q   <= pc_next;
      if (inst_load) inst_q <= bus.imem_rdata;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Free-running counters; both stop while halted and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q   <= cycle_q + 32'd1;
      if (retire)            instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: an instruction-level model expands each directed
// instruction into its expected cycle-by-cycle trace, which is replayed on the DUT
// and compared every cycle.
module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [16:0] full_inst;
  logic        rd_e, jump_e, branch_taken;
  logic [31:0] alu_result;
  logic        rf_we, retire, halt;
  logic [1:0]  wb_sel;
  logic [31:0] pc, cycle_cnt, instret_cnt;

  core_sequencer_if bus ();

  core_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inst         (inst),
    .full_inst    (full_inst),
    .rd_e         (rd_e),
    .jump_e       (jump_e),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .pc           (pc),
    .retire       (retire),
    .halt         (halt),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  // Stand-in decoder: func7, func3, opcode straight from the latched word.
  assign full_inst = {inst[31:25], inst[14:12], inst[6:0]};

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ir, dr, rd, jmp, tk;
    logic [31:0] rdata, alu;
    logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_ret, e_halt;
    logic [1:0]  e_wbs;
    logic [31:0] e_pc, e_inst, e_cyc, e_iret;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  logic cur_valid = 1'b0;
  int   cur_idx = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state (architectural view only).
  logic [31:0] m_pc, m_inst, m_cyc, m_ret;
  logic        m_halted;
  logic [31:0] c_word, c_alu;
  logic        c_rd, c_jmp, c_tk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vec %0d: got %h want %h", nm, cur_idx, act, exp);
    end
  endtask

  task automatic emit(input logic ir, input logic dr, input logic ireq, input logic dreq,
                      input logic dwe, input logic rfwe, input logic [1:0] wbs, input logic ret);
    vec_t v;
    v.rst = 1'b0; v.ir = ir; v.dr = dr;
    v.rdata = ir ? c_word : 32'hDEAD_BEEF;
    v.rd = c_rd; v.jmp = c_jmp; v.tk = c_tk; v.alu = c_alu;
    v.e_ireq = ireq; v.e_dreq = dreq; v.e_dwe = dwe; v.e_rfwe = rfwe;
    v.e_wbs = wbs; v.e_ret = ret; v.e_halt = m_halted;
    v.e_pc = m_pc; v.e_inst = m_inst;
`ifdef SEQ_PERF_CNT_EN
    v.e_cyc = m_cyc; v.e_iret = m_ret;
`else
    v.e_cyc = 32'd0; v.e_iret = 32'd0;
`endif
    vq.push_back(v);
    if (!m_halted) m_cyc = m_cyc + 32'd1;
  endtask

  task automatic add_reset(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '{default: '0};
      v.rst = 1'b1; v.ir = 1'b1; v.dr = 1'b1; v.rdata = 32'hFFFF_FFFF;
      vq.push_back(v);
    end
    m_pc = RST_PC; m_inst = 32'h0000_0013; m_cyc = 0; m_ret = 0; m_halted = 1'b0;
  endtask

  task automatic add_halt(input int n);
    for (int i = 0; i < n; i++) emit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Expands one instruction into its cycle trace; returns the number of cycles.
  task automatic add_inst(input logic [31:0] w, input int iw, input int dw, input logic rd,
                          input logic jmp, input logic [31:0] alu, input logic tk,
                          input logic abort_mem, output int ncyc);
    int          n0;
    logic [6:0]  op;
    logic        ld, st, br, stop;
    logic [31:0] npc;
    logic        mis;
    n0 = vq.size();
    op = w[6:0];
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    br = (op == 7'b1100011);
    stop = (op == 7'b1110011) || (op == 7'd0);
    c_word = w; c_rd = rd; c_jmp = jmp; c_alu = alu; c_tk = tk;
    if (jmp)          npc = {alu[31:1], 1'b0};
    else if (br && tk) npc = alu;
    else              npc = m_pc + 32'd4;
    mis = (npc[1:0] != 2'b00);
    for (int i = 0; i < iw; i++) emit(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    emit(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    m_inst = w;
    emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    if (stop) begin
      m_halted = 1'b1;
    end else begin
      emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      if (ld || st)
        for (int i = 0; i < dw; i++) emit(1'b0, 1'b0, 1'b0, 1'b1, st, 1'b0, 2'd0, 1'b0);
      if (!((ld || st) && abort_mem)) begin
        if (st) begin
          emit(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, !mis);
        end else begin
          if (ld) emit(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
          emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd, ld ? 2'd1 : (jmp ? 2'd2 : 2'd0), !mis);
        end
        if (mis) begin
          m_halted = 1'b1;
        end else begin
          m_pc  = npc;
          m_ret = m_ret + 32'd1;
        end
      end
    end
    ncyc = vq.size() - n0;
  endtask

  task automatic build();
    int n;
    add_reset(2);
    add_inst(32'h0050_0093, 0, 0, 1, 0, 32'h5, 0, 0, n);          // addi x1,x0,5
    chk("addi_latency", n, 4);
    chk("addi_pc", m_pc, 32'h4);
    chk("addi_c4_rfwe", {31'd0, vq[vq.size()-1].e_rfwe}, 1);
    add_inst(32'h0000_2103, 0, 3, 1, 0, 32'h0, 0, 0, n);          // lw x2,0(x0)
    chk("lw_latency", n, 8);
    chk("lw_wbsel", {30'd0, vq[vq.size()-1].e_wbs}, 1);
    add_inst(32'h0010_0463, 0, 0, 0, 0, 32'h40, 0, 0, n);         // beq not taken
    chk("bnt_pc", m_pc, 32'hC);
    add_inst(32'h0010_2023, 2, 1, 0, 0, 32'h100, 0, 0, n);        // sw with waits
    chk("sw_latency", n, 7);
    add_inst(32'h0080_00EF, 0, 0, 1, 1, 32'h18, 0, 0, n);         // jal x1,+8 at 0x10
    chk("jal_pc", m_pc, 32'h18);
    add_inst(32'h0000_8067, 0, 0, 0, 1, 32'h9, 0, 0, n);          // jalr -> 0x8
    chk("jalr_pc", m_pc, 32'h8);
    add_inst(32'h0010_0463, 0, 0, 0, 0, 32'h40, 1, 0, n);         // beq taken
    chk("bt_pc", m_pc, 32'h40);
    add_inst(32'h0080_00EF, 0, 0, 1, 1, 32'h10, 0, 0, n);         // back to 0x10
    add_inst(32'h0080_00EF, 0, 0, 1, 1, 32'h1A, 0, 0, n);         // misaligned jal
    chk("jal_mis_pc", m_pc, 32'h10);
    chk("jal_mis_ret", {31'd0, vq[vq.size()-1].e_ret}, 0);
    add_halt(3);
    add_reset(1);
    add_inst(32'h0000_0073, 1, 0, 0, 0, 32'h0, 0, 0, n);          // ecall
    chk("ecall_cycles", n, 3);
    add_halt(2);
    add_reset(1);
    add_inst(32'h0000_000F, 0, 0, 1, 0, 32'h0, 0, 0, n);          // fence
    add_inst(32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 0, n);          // undecodable
    add_halt(1);
    add_reset(1);
    add_inst(32'h0000_2103, 0, 2, 1, 0, 32'h0, 0, 1, n);          // lw aborted in MEM
    chk("abort_cycles", n, 5);
    add_reset(1);
    add_inst(32'h0050_0093, 0, 0, 1, 0, 32'h5, 0, 0, n);
    chk("post_abort_ret", m_ret, 1);
    add_inst(32'h0000_8067, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, n);
    add_inst(32'h0050_0093, 1, 0, 1, 0, 32'h5, 0, 0, n);
    chk("pc_wrap", m_pc, 32'h0);
    add_inst(32'h0010_0463, 0, 0, 0, 0, 32'h42, 1, 0, n);         // misaligned branch
    add_halt(2);
  endtask

  // Per-cycle compare against the replayed trace.
  always @(negedge clk) begin
    if (cur_valid) begin
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, cur.e_ireq});
      if (!cur.rst) begin
        chk("imem_addr", bus.imem_addr, cur.e_pc);
        chk("pc", pc, cur.e_pc);
        chk("inst", inst, cur.e_inst);
        chk("dmem_req", {31'd0, bus.dmem_req}, {31'd0, cur.e_dreq});
        chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, cur.e_dwe});
        chk("dmem_addr", bus.dmem_addr, cur.alu);
        chk("rf_we", {31'd0, rf_we}, {31'd0, cur.e_rfwe});
        chk("wb_sel", {30'd0, wb_sel}, {30'd0, cur.e_wbs});
        chk("retire", {31'd0, retire}, {31'd0, cur.e_ret});
        chk("halt", {31'd0, halt}, {31'd0, cur.e_halt});
        chk("cycle_cnt", cycle_cnt, cur.e_cyc);
        chk("instret_cnt", instret_cnt, cur.e_iret);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
    rd_e = 1'b0; jump_e = 1'b0; alu_result = '0; branch_taken = 1'b0;
    build();
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst            = vq[i].rst;
      bus.imem_ready = vq[i].ir;
      bus.imem_rdata = vq[i].rdata;
      bus.dmem_ready = vq[i].dr;
      rd_e           = vq[i].rd;
      jump_e         = vq[i].jmp;
      alu_result     = vq[i].alu;
      branch_taken   = vq[i].tk;
      cur            = vq[i];
      cur_idx        = i;
      cur_valid      = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
